glitch_sweep_sequencer: RTL and testbench
=========================================

Name: glitch_sweep_sequencer

Overview:
Autonomous sweep controller for the glitch timing chain (resetter → offset_counter → duration_counter). Given offset/duration ranges from the command processor, it drives the target-reset request, sets the glitch offset/duration values and pulses start-offset for each attempt. It then watches a success indication from the target UART path and reports the first or every hit. It sits between command_processor and the reset/offset/duration blocks and replaces manual per-attempt PC commands.

Parameters:
W, 32, width of offset/duration values and attempt counter
RST_CYCLES, 1000, sys_clk cycles target_reset_req held high per attempt
TIMEOUT_CYCLES, 2**24, max cycles waiting for glitch_done before forcing evaluation
OBS_CYCLES, 100000, observation window after glitch for success_in
CW, 25, internal cycle-counter width; must hold max(RST_CYCLES, TIMEOUT_CYCLES, OBS_CYCLES)

Ports:
clk  in  1  system clock (PLL output)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin sweep (ignored while busy)
abort  in  1  one-cycle pulse; stop sweep
stop_on_hit  in  1  sampled at start; 1 = finish at first hit
ofs_start / ofs_end / ofs_step  in  W each  offset range, sampled at start
dur_start / dur_end / dur_step  in  W each  duration range, sampled at start
repeats  in  8  attempts per point, sampled at start; 0 treated as 1
glitch_done  in  1  pulse from duration chain when glitch pulse ends
success_in  in  1  level/pulse from target-response detector
target_reset_req  out  1  to resetter and counter resets
glitch_offset  out  W  to offset_counter din
glitch_duration  out  W  to duration_counter din
start_offset_counter  out  1  one-cycle arm pulse
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at sweep completion or abort
hit  out  1  one-cycle pulse per successful attempt
hit_offset / hit_duration  out  W each  values of the most recent hit
attempts  out  W  attempts issued since last start, saturating

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs 0, including latched config and hit registers.
- IDLE: on start, latch config, ofs_cur=ofs_start, dur_cur=dur_start, rep=0, attempts=0 → RESET. A step of 0 is latched as 1.
- RESET: target_reset_req=1 for exactly RST_CYCLES cycles → ARM. glitch_offset/glitch_duration = ofs_cur/dur_cur from RESET entry and held stable through EVAL.
- ARM: start_offset_counter=1 for one cycle, attempts+=1 (saturates at all-ones) → WAIT.
- WAIT: on glitch_done → OBS. If TIMEOUT_CYCLES elapse with no glitch_done → OBS anyway; no error flag.
- OBS: runs OBS_CYCLES cycles. Any cycle with success_in=1 sets the internal hit_flag; success_in in other states is ignored. End of window → EVAL.
- EVAL (1 cycle):
  - If hit_flag: hit=1, hit_offset=ofs_cur, hit_duration=dur_cur. If stop_on_hit → DONE.
  - Otherwise advance: if rep+1 < repeats → rep+=1.
  - Else rep=0 and dur_next = dur_cur + dur_step, computed in W+1 bits. If dur_next > dur_end → dur_cur=dur_start and ofs_next = ofs_cur + ofs_step (W+1 bits). If ofs_next > ofs_end → DONE, else ofs_cur=ofs_next.
  - If not done → RESET. Clear hit_flag.
- Range edge cases:
  - start > end on either axis: exactly one point per that axis is tested (the start value).
  - Step overflow past 2^W terminates the axis and never wraps.
- DONE: done=1 one cycle → IDLE. busy low in the same cycle done is high.
- abort (any non-IDLE state): next state is DONE. target_reset_req and start_offset_counter drop on the next clock. Abort has priority over every other transition, including a simultaneous hit in EVAL; the hit is still reported if EVAL is the current state.
- start while busy: ignored. start and abort together in IDLE: start wins, abort is ignored.
- All outputs are registered; start → target_reset_req rising latency is 1 cycle.

Decomposition:
- Shared package glitch_pkg: state enum (IDLE, RESET, ARM, WAIT, OBS, EVAL, DONE), W default, attempt/cycle-counter widths.
- One natural sub-module: sweep_point_gen. It holds the ofs/dur/rep registers and implements the advance/wrap/last-point logic, with inputs load, advance and outputs ofs_cur, dur_cur, last. The FSM and cycle counter stay in the top of this block.

Test Plan:
- Single point (RST_CYCLES=4, OBS_CYCLES=8): ofs 10..10, dur 3..3, repeats 1, glitch_done 5 cycles after arm, no success → target_reset_req high exactly 4 cycles, one arm pulse with glitch_offset=10 and glitch_duration=3, attempts=1, done once, hit never.
- 2-D sweep: ofs 0..4 step 2, dur 1..2 step 1, repeats 2 → 12 attempts in order (0,1)(0,1)(0,2)(0,2)(2,1)…(4,2), then done.
- stop_on_hit=1 with success_in asserted in the OBS of the point (2,2) → hit pulse, hit_offset=2, hit_duration=2, done next cycle, attempts=4 (repeats=1).
- Missing glitch_done with TIMEOUT_CYCLES=16 → OBS entered exactly 16 cycles after the arm pulse; the sweep proceeds normally.
- abort issued during RESET of the 2nd attempt → target_reset_req low next cycle, done pulse, busy low. A start during the sweep has no effect. A fresh start restarts from ofs_start.
- Boundary: ofs_start=2^32-2, ofs_end=2^32-1, step 5 → one offset tested, no wrap to small offsets. rst_n asserted mid-OBS → all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/glitch_sweep_sequencer_pkg.sv
// Shared types and defaults for the glitch sweep sequencer.
package glitch_pkg;
  localparam int unsigned W_DEF  = 32;
  localparam int unsigned CW_DEF = 25;
  localparam int unsigned REP_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_ARM,
    ST_WAIT,
    ST_OBS,
    ST_EVAL,
    ST_DONE
  } state_t;
endpackage

// File: rtl/glitch_sweep_sequencer_point_gen.sv
// Offset/duration/repeat walker: holds the current sweep point and the latched ranges.
module sweep_point_gen
  import glitch_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic [W-1:0]     ofs_start,
  input  logic [W-1:0]     ofs_end,
  input  logic [W-1:0]     ofs_step,
  input  logic [W-1:0]     dur_start,
  input  logic [W-1:0]     dur_end,
  input  logic [W-1:0]     dur_step,
  input  logic [REP_W-1:0] repeats,
  output logic [W-1:0]     ofs_cur,
  output logic [W-1:0]     dur_cur,
  output logic             last
);

  logic [W-1:0]     ofs_q, ofs_d, dur_q, dur_d;
  logic [W-1:0]     ofs_end_q, ofs_end_d, ofs_step_q, ofs_step_d;
  logic [W-1:0]     dur_start_q, dur_start_d, dur_end_q, dur_end_d, dur_step_q, dur_step_d;
  logic [REP_W-1:0] rep_q, rep_d, rep_max_q, rep_max_d;
  logic [REP_W:0]   rep_inc;
  logic [W:0]       dur_sum, ofs_sum;
  logic             rep_wrap, dur_wrap, ofs_wrap;

  always_comb begin
    // Sums carry one extra bit so a step past 2^W ends the axis instead of wrapping.
    rep_inc  = {1'b0, rep_q} + (REP_W+1)'(1);
    dur_sum  = {1'b0, dur_q} + {1'b0, dur_step_q};
    ofs_sum  = {1'b0, ofs_q} + {1'b0, ofs_step_q};
    rep_wrap = rep_inc >= {1'b0, rep_max_q};
    dur_wrap = dur_sum > {1'b0, dur_end_q};
    ofs_wrap = ofs_sum > {1'b0, ofs_end_q};
    last     = rep_wrap && dur_wrap && ofs_wrap;

    ofs_d       = ofs_q;
    dur_d       = dur_q;
    rep_d       = rep_q;
    ofs_end_d   = ofs_end_q;
    ofs_step_d  = ofs_step_q;
    dur_start_d = dur_start_q;
    dur_end_d   = dur_end_q;
    dur_step_d  = dur_step_q;
    rep_max_d   = rep_max_q;

    if (load) begin
      ofs_d       = ofs_start;
      dur_d       = dur_start;
      rep_d       = '0;
      ofs_end_d   = ofs_end;
      ofs_step_d  = (ofs_step == '0) ? W'(1) : ofs_step;
      dur_start_d = dur_start;
      dur_end_d   = dur_end;
      dur_step_d  = (dur_step == '0) ? W'(1) : dur_step;
      rep_max_d   = (repeats == '0) ? REP_W'(1) : repeats;
    end else if (advance && !last) begin
      if (!rep_wrap) begin
        rep_d = rep_inc[REP_W-1:0];
      end else begin
        rep_d = '0;
        if (dur_wrap) begin
          dur_d = dur_start_q;
          ofs_d = ofs_sum[W-1:0];
        end else begin
          dur_d = dur_sum[W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofs_q       <= '0;
      dur_q       <= '0;
      rep_q       <= '0;
      ofs_end_q   <= '0;
      ofs_step_q  <= '0;
      dur_start_q <= '0;
      dur_end_q   <= '0;
      dur_step_q  <= '0;
      rep_max_q   <= '0;
    end else begin
      ofs_q       <= ofs_d;
      dur_q       <= dur_d;
      rep_q       <= rep_d;
      ofs_end_q   <= ofs_end_d;
      ofs_step_q  <= ofs_step_d;
      dur_start_q <= dur_start_d;
      dur_end_q   <= dur_end_d;
      dur_step_q  <= dur_step_d;
      rep_max_q   <= rep_max_d;
    end
  end

  assign ofs_cur = ofs_q;
  assign dur_cur = dur_q;

endmodule

// File: rtl/glitch_sweep_sequencer.sv
// Autonomous glitch sweep: reset target, arm offset counter, wait for glitch, observe, step.
module glitch_sweep_sequencer
  import glitch_pkg::*;
#(
  parameter int unsigned W              = W_DEF,
  parameter int unsigned RST_CYCLES     = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 2**24,
  parameter int unsigned OBS_CYCLES     = 100000,
  parameter int unsigned CW             = CW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             stop_on_hit,
  input  logic [W-1:0]     ofs_start,
  input  logic [W-1:0]     ofs_end,
  input  logic [W-1:0]     ofs_step,
  input  logic [W-1:0]     dur_start,
  input  logic [W-1:0]     dur_end,
  input  logic [W-1:0]     dur_step,
  input  logic [REP_W-1:0] repeats,
  input  logic             glitch_done,
  input  logic             success_in,
  output logic             target_reset_req,
  output logic [W-1:0]     glitch_offset,
  output logic [W-1:0]     glitch_duration,
  output logic             start_offset_counter,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [W-1:0]     hit_offset,
  output logic [W-1:0]     hit_duration,
  output logic [W-1:0]     attempts
);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] OBS_LAST = CW'(OBS_CYCLES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hit_flag_q, hit_flag_d, stop_q, stop_d;
  logic          trr_q, trr_d, soc_q, soc_d, busy_q, busy_d, done_q, done_d, hit_q, hit_d;
  logic [W-1:0]  hit_ofs_q, hit_ofs_d, hit_dur_q, hit_dur_d, attempts_q, attempts_d;
  logic          load, advance, last;
  logic [W-1:0]  ofs_cur, dur_cur;

  sweep_point_gen #(.W(W)) u_point (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .advance   (advance),
    .ofs_start (ofs_start),
    .ofs_end   (ofs_end),
    .ofs_step  (ofs_step),
    .dur_start (dur_start),
    .dur_end   (dur_end),
    .dur_step  (dur_step),
    .repeats   (repeats),
    .ofs_cur   (ofs_cur),
    .dur_cur   (dur_cur),
    .last      (last)
  );

  always_comb begin
    state_d    = state_q;
    hit_flag_d = hit_flag_q;
    stop_d     = stop_q;
    load       = 1'b0;
    advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        hit_flag_d = 1'b0;
        if (start) begin
          state_d = ST_RESET;
          load    = 1'b1;
          stop_d  = stop_on_hit;
        end
      end
      ST_RESET: if (cnt_q == RST_LAST) state_d = ST_ARM;
      ST_ARM:   state_d = ST_WAIT;
      ST_WAIT:  if (glitch_done || cnt_q == TO_LAST) state_d = ST_OBS;
      ST_OBS: begin
        if (success_in) hit_flag_d = 1'b1;
        if (cnt_q == OBS_LAST) state_d = ST_EVAL;
      end
      ST_EVAL: begin
        hit_flag_d = 1'b0;
        if ((hit_flag_q && stop_q) || last) begin
          state_d = ST_DONE;
        end else begin
          advance = 1'b1;
          state_d = ST_RESET;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_d = ST_DONE;
      advance = 1'b0;
    end

    // The timeout window is measured from the arm pulse, so ARM->WAIT keeps counting.
    if (state_q == ST_IDLE || (state_d != state_q && state_q != ST_ARM)) cnt_d = '0;
    else cnt_d = cnt_q + CW'(1);

    trr_d     = (state_d == ST_RESET);
    soc_d     = (state_d == ST_ARM);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    hit_d     = (state_d == ST_EVAL) && hit_flag_d;
    hit_ofs_d = hit_d ? ofs_cur : hit_ofs_q;
    hit_dur_d = hit_d ? dur_cur : hit_dur_q;

    if (load) attempts_d = '0;
    else if (soc_d && attempts_q != '1) attempts_d = attempts_q + W'(1);
    else attempts_d = attempts_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      hit_flag_q <= 1'b0;
      stop_q     <= 1'b0;
      trr_q      <= 1'b0;
      soc_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      hit_ofs_q  <= '0;
      hit_dur_q  <= '0;
      attempts_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hit_flag_q <= hit_flag_d;
      stop_q     <= stop_d;
      trr_q      <= trr_d;
      soc_q      <= soc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      hit_ofs_q  <= hit_ofs_d;
      hit_dur_q  <= hit_dur_d;
      attempts_q <= attempts_d;
    end
  end

  assign target_reset_req     = trr_q;
  assign start_offset_counter = soc_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign hit                  = hit_q;
  assign hit_offset           = hit_ofs_q;
  assign hit_duration         = hit_dur_q;
  assign attempts             = attempts_q;
  assign glitch_offset        = ofs_cur;
  assign glitch_duration      = dur_cur;

endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// Directed bench for glitch_sweep_sequencer with short reset/timeout/observation windows.
module tb_glitch_sweep_sequencer;
  localparam int unsigned W = 32;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, stop_on_hit = 1'b0;
  logic [W-1:0] ofs_start = '0, ofs_end = '0, ofs_step = '0;
  logic [W-1:0] dur_start = '0, dur_end = '0, dur_step = '0;
  logic [7:0]   repeats = '0;
  logic         glitch_done = 1'b0;
  logic         success_in;
  logic         target_reset_req, start_offset_counter, busy, done, hit;
  logic [W-1:0] glitch_offset, glitch_duration, hit_offset, hit_duration, attempts;

  int total = 0, bad = 0, cyc = 0, start_cyc = 0;
  logic         succ_en = 1'b0, succ_force = 1'b0, mon_clr = 1'b0;
  logic [W-1:0] succ_ofs = '0, succ_dur = '0;
  bit           gd_en = 1'b1, trr_prev = 1'b0;
  int           gd_cnt = 0;
  logic [W-1:0] arm_ofs [64];
  logic [W-1:0] arm_dur [64];
  int           arm_cyc [64];
  int n_arm = 0, rise_cyc = 0, n_rise = 0, trr_cycles = 0;
  int n_done = 0, done_cyc = 0, done_busy = 0, n_hit = 0, hit_cyc = 0;

  glitch_sweep_sequencer #(
    .W(W), .RST_CYCLES(4), .TIMEOUT_CYCLES(16), .OBS_CYCLES(8), .CW(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .stop_on_hit(stop_on_hit),
    .ofs_start(ofs_start), .ofs_end(ofs_end), .ofs_step(ofs_step),
    .dur_start(dur_start), .dur_end(dur_end), .dur_step(dur_step),
    .repeats(repeats), .glitch_done(glitch_done), .success_in(success_in),
    .target_reset_req(target_reset_req), .glitch_offset(glitch_offset),
    .glitch_duration(glitch_duration), .start_offset_counter(start_offset_counter),
    .busy(busy), .done(done), .hit(hit), .hit_offset(hit_offset),
    .hit_duration(hit_duration), .attempts(attempts)
  );

  assign success_in = (succ_en && glitch_offset == succ_ofs && glitch_duration == succ_dur) || succ_force;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor and glitch_done responder (glitch_done 5 cycles after each arm pulse).
  always @(negedge clk) begin
    if (mon_clr) begin
      n_arm = 0; n_rise = 0; trr_cycles = 0; n_done = 0; done_busy = 0; n_hit = 0;
    end
    if (target_reset_req) begin
      trr_cycles++;
      if (!trr_prev) begin
        n_rise++;
        if (n_rise == 1) rise_cyc = cyc;
      end
    end
    trr_prev = target_reset_req;
    if (start_offset_counter) begin
      if (n_arm < 64) begin
        arm_ofs[n_arm] = glitch_offset;
        arm_dur[n_arm] = glitch_duration;
        arm_cyc[n_arm] = cyc;
      end
      n_arm++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      if (busy) done_busy++;
    end
    if (hit) begin
      n_hit++;
      hit_cyc = cyc;
    end
    glitch_done = 1'b0;
    if (start_offset_counter) gd_cnt = gd_en ? 5 : 0;
    else if (gd_cnt > 0) begin
      gd_cnt--;
      if (gd_cnt == 0) glitch_done = 1'b1;
    end
  end

  task automatic start_sweep(input logic [W-1:0] os, oe, ost, ds, de, dst,
                             input logic [7:0] rp, input logic soh, input logic ab);
    @(posedge clk); #1;
    ofs_start = os; ofs_end = oe; ofs_step = ost;
    dur_start = ds; dur_end = de; dur_step = dst;
    repeats = rp; stop_on_hit = soh;
    start = 1'b1; abort = ab; mon_clr = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (n_done > 0) break;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_arm(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (start_offset_counter) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [164:0] snap;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    snap = {target_reset_req, glitch_offset, glitch_duration, start_offset_counter, busy,
            done, hit, hit_offset, hit_duration, attempts};
    total++;
    if (snap !== '0) begin bad++; $display("FAIL reset_outputs: got %h expected 0", snap); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_point();
    gd_en = 1'b1;
    start_sweep(10, 10, 1, 3, 3, 1, 1, 0, 0);
    wait_done(200);
    total++; if (n_done !== 1) begin bad++; $display("FAIL single_done_count: got %0d expected 1", n_done); end
    total++; if (trr_cycles !== 4) begin bad++; $display("FAIL single_trr_cycles: got %0d expected 4", trr_cycles); end
    total++; if (rise_cyc !== start_cyc + 1) begin bad++; $display("FAIL single_trr_latency: got %0d expected %0d", rise_cyc - start_cyc, 1); end
    total++; if (n_arm !== 1) begin bad++; $display("FAIL single_arm_count: got %0d expected 1", n_arm); end
    total++; if (arm_ofs[0] !== 32'd10) begin bad++; $display("FAIL single_arm_ofs: got %0d expected 10", arm_ofs[0]); end
    total++; if (arm_dur[0] !== 32'd3) begin bad++; $display("FAIL single_arm_dur: got %0d expected 3", arm_dur[0]); end
    total++; if (attempts !== 32'd1) begin bad++; $display("FAIL single_attempts: got %0d expected 1", attempts); end
    total++; if (n_hit !== 0) begin bad++; $display("FAIL single_hit_count: got %0d expected 0", n_hit); end
    total++; if (done_cyc - start_cyc !== 20) begin bad++; $display("FAIL single_done_latency: got %0d expected 20", done_cyc - start_cyc); end
    total++; if (done_busy !== 0) begin bad++; $display("FAIL single_busy_with_done: got %0d expected 0", done_busy); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %0b expected 0", busy); end
  endtask

  task automatic test_sweep_2d();
    logic [W-1:0] exp_o [12];
    logic [W-1:0] exp_d [12];
    int k = 0;
    for (int o = 0; o <= 4; o += 2)
      for (int d = 1; d <= 2; d++)
        for (int r = 0; r < 2; r++) begin
          exp_o[k] = W'(o); exp_d[k] = W'(d); k++;
        end
    start_sweep(0, 4, 2, 1, 2, 1, 2, 0, 0);
    wait_done(1000);
    total++; if (n_arm !== 12) begin bad++; $display("FAIL sweep_arm_count: got %0d expected 12", n_arm); end
    for (int i = 0; i < 12; i++) begin
      total++;
      if (arm_ofs[i] !== exp_o[i] || arm_dur[i] !== exp_d[i]) begin
        bad++;
        $display("FAIL sweep_point[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, arm_ofs[i], arm_dur[i], exp_o[i], exp_d[i]);
      end
    end
    total++; if (attempts !== 32'd12) begin bad++; $display("FAIL sweep_attempts: got %0d expected 12", attempts); end
    total++; if (n_done !== 1) begin bad++; $display("FAIL sweep_done_count: got %0d expected 1", n_done); end
  endtask

  task automatic test_stop_on_hit();
    succ_en = 1'b1; succ_ofs = 2; succ_dur = 2;
    start_sweep(0, 4, 2, 1, 2, 1, 1, 1, 0);
    wait_done(1000);
    succ_en = 1'b0;
    total++; if (n_hit !== 1) begin bad++; $display("FAIL soh_hit_count: got %0d expected 1", n_hit); end
    total++; if (hit_offset !== 32'd2) begin bad++; $display("FAIL soh_hit_offset: got %0d expected 2", hit_offset); end
    total++; if (hit_duration !== 32'd2) begin bad++; $display("FAIL soh_hit_duration: got %0d expected 2", hit_duration); end
    total++; if (done_cyc !== hit_cyc + 1) begin bad++; $display("FAIL soh_done_after_hit: got %0d expected 1", done_cyc - hit_cyc); end
    total++; if (attempts !== 32'd4) begin bad++; $display("FAIL soh_attempts: got %0d expected 4", attempts); end
    total++; if (n_arm !== 4) begin bad++; $display("FAIL soh_arm_count: got %0d expected 4", n_arm); end
  endtask

  task automatic test_timeout();
    bit ok;
    gd_en = 1'b0;
    for (int off = 15; off <= 16; off++) begin
      start_sweep(7, 7, 1, 9, 9, 1, 1, 0, 0);
      wait_arm(50, ok);
      total++; if (!ok) begin bad++; $display("FAIL timeout_arm_seen: got 0 expected 1"); end
      repeat (off) @(negedge clk);
      succ_force = 1'b1;
      @(negedge clk);
      succ_force = 1'b0;
      wait_done(200);
      total++;
      if (n_hit !== ((off == 16) ? 1 : 0)) begin
        bad++; $display("FAIL timeout_obs_edge_%0d: got %0d expected %0d", off, n_hit, (off == 16) ? 1 : 0);
      end
      total++; if (done_cyc - arm_cyc[0] !== 25) begin bad++; $display("FAIL timeout_done_latency: got %0d expected 25", done_cyc - arm_cyc[0]); end
      total++; if (n_done !== 1) begin bad++; $display("FAIL timeout_done_count: got %0d expected 1", n_done); end
    end
    gd_en = 1'b1;
  endtask

  task automatic test_abort();
    bit ok;
    start_sweep(5, 9, 1, 1, 1, 1, 1, 0, 0);
    wait_arm(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_first_arm: got 0 expected 1"); end
    @(posedge clk); #1;
    ofs_start = 50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ofs_start = 5;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (target_reset_req) break;
    end
    total++; if (target_reset_req !== 1'b1) begin bad++; $display("FAIL abort_second_reset: got %0b expected 1", target_reset_req); end
    total++; if (glitch_offset !== 32'd6) begin bad++; $display("FAIL abort_busy_start_ignored: got %0d expected 6", glitch_offset); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    total++; if (target_reset_req !== 1'b0) begin bad++; $display("FAIL abort_trr_drop: got %0b expected 0", target_reset_req); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_done: got %0b expected 1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %0b expected 0", busy); end
    repeat (3) @(negedge clk);
    total++; if (n_arm !== 1 || n_done !== 1) begin bad++; $display("FAIL abort_counts: got arm=%0d done=%0d expected arm=1 done=1", n_arm, n_done); end
    start_sweep(30, 30, 1, 4, 4, 1, 1, 0, 1);
    wait_done(200);
    total++; if (rise_cyc !== start_cyc + 1) begin bad++; $display("FAIL restart_start_wins: got %0d expected 1", rise_cyc - start_cyc); end
    total++; if (n_arm !== 1 || arm_ofs[0] !== 32'd30) begin bad++; $display("FAIL restart_point: got arm=%0d ofs=%0d expected arm=1 ofs=30", n_arm, arm_ofs[0]); end
    total++; if (attempts !== 32'd1) begin bad++; $display("FAIL restart_attempts: got %0d expected 1", attempts); end
  endtask

  task automatic test_boundary();
    start_sweep(32'hFFFF_FFFE, 32'hFFFF_FFFF, 5, 0, 0, 0, 0, 0, 0);
    wait_done(300);
    total++; if (n_arm !== 1) begin bad++; $display("FAIL ovf_arm_count: got %0d expected 1", n_arm); end
    total++; if (arm_ofs[0] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL ovf_arm_ofs: got %h expected fffffffe", arm_ofs[0]); end
    total++; if (n_done !== 1 || attempts !== 32'd1) begin bad++; $display("FAIL ovf_done: got done=%0d att=%0d expected 1/1", n_done, attempts); end
    start_sweep(10, 3, 1, 8, 2, 1, 1, 0, 0);
    wait_done(300);
    total++;
    if (n_arm !== 1 || arm_ofs[0] !== 32'd10 || arm_dur[0] !== 32'd8) begin
      bad++; $display("FAIL inverted_range: got arm=%0d (%0d,%0d) expected arm=1 (10,8)", n_arm, arm_ofs[0], arm_dur[0]);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [164:0] snap;
    start_sweep(77, 77, 1, 5, 5, 1, 1, 0, 0);
    wait_arm(50, ok);
    repeat (8) @(negedge clk);
    total++; if (busy !== 1'b1 || hit_offset === '0) begin bad++; $display("FAIL midobs_precondition: got busy=%0b hit_ofs=%0d expected busy=1 hit_ofs!=0", busy, hit_offset); end
    rst_n = 1'b0;
    #1;
    snap = {target_reset_req, glitch_offset, glitch_duration, start_offset_counter, busy,
            done, hit, hit_offset, hit_duration, attempts};
    total++; if (snap !== '0) begin bad++; $display("FAIL midobs_async_reset: got %h expected 0", snap); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_point();
    test_sweep_2d();
    test_stop_on_hit();
    test_timeout();
    test_abort();
    test_boundary();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
